// File: rtl/seq_divider_if.sv
// Request/response bundle for seq_divider: operand handshake in, result handshake out.
// master is the requester/consumer side, slave is the divider.
interface seq_divider_if #(
    parameter int N = 4
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] dividend;
    logic [N-1:0] divisor;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] quotient;
    logic [N-1:0] remainder;
    logic         div_by_zero;
    logic         zero;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, div_by_zero, zero
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, div_by_zero, zero
    );
endinterface

// File: rtl/seq_divider.sv
// Unsigned restoring divider producing one quotient bit per clock, with
// valid/ready handshakes on operands and result plus zero / divide-by-zero flags.
//
// state | meaning
// IDLE  | in_ready high, waiting for an operand request
// BUSY  | shifting/subtracting one quotient bit per edge (or finishing a zero-divisor request)
// DONE  | out_valid high, result held until out_ready
module seq_divider #(
    parameter int N = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    seq_divider_if.slave bus
);
    localparam int CW = (N > 2) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(N - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state;
    logic [N-1:0]  r;
    logic [N-1:0]  q;
    logic [N-1:0]  d;
    logic [CW-1:0] cnt;
    logic          dz_pend;

    logic [N-1:0]  quotient_q;
    logic [N-1:0]  remainder_q;
    logic          div_by_zero_q;
    logic          zero_q;

    logic [N:0]    s;
    logic [N:0]    t;
    logic [N-1:0]  r_next;
    logic [N-1:0]  q_next;

    // The partial remainder always stays below the divisor, so N bits hold it;
    // the trial subtraction itself is N+1 bits so the borrow never wraps.
    always_comb begin
        s      = {r, q[N-1]};
        t      = s - {1'b0, d};
        r_next = t[N] ? s[N-1:0] : t[N-1:0];
        q_next = {q[N-2:0], ~t[N]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            r             <= '0;
            q             <= '0;
            d             <= '0;
            cnt           <= '0;
            dz_pend       <= 1'b0;
            quotient_q    <= '0;
            remainder_q   <= '0;
            div_by_zero_q <= 1'b0;
            zero_q        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        state   <= BUSY;
                        r       <= '0;
                        q       <= bus.dividend;
                        d       <= bus.divisor;
                        cnt     <= CNT_INIT;
                        dz_pend <= (bus.divisor == '0);
                    end
                end
                BUSY: begin
                    // A zero divisor spends exactly one BUSY edge before its result appears.
                    if (dz_pend) begin
                        state         <= DONE;
                        dz_pend       <= 1'b0;
                        quotient_q    <= '1;
                        remainder_q   <= q;
                        div_by_zero_q <= 1'b1;
                        zero_q        <= 1'b0;
                    end else begin
                        r <= r_next;
                        q <= q_next;
                        if (cnt == '0) begin
                            state         <= DONE;
                            quotient_q    <= q_next;
                            remainder_q   <= r_next;
                            div_by_zero_q <= 1'b0;
                            zero_q        <= (q_next == '0);
                        end else begin
                            cnt <= cnt - CW'(1);
                        end
                    end
                end
                DONE: begin
                    if (bus.out_ready) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = (state == DONE);
    assign bus.quotient    = quotient_q;
    assign bus.remainder   = remainder_q;
    assign bus.div_by_zero = div_by_zero_q;
    assign bus.zero        = zero_q;
endmodule
